// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: CRC-32 constants, frame limits,
// the byte-wide CRC helper and the checker FSM state type.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          ETH_MIN_FRAME = 64;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_IN_FRAME = 1'b1
  } state_t;

  // Reflected CRC-32, one byte absorbed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide CRC-32 register. init restarts from CRC32_INIT on the same
// beat that absorbs the byte; crc_next_o is the value after this byte.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o,
  output logic [31:0] crc_next_o
);

  logic [31:0] crc_q;

  assign crc_next_o = crc32_byte(init_i ? CRC32_INIT : crc_q, data_i);
  assign crc_o      = crc_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)   crc_q <= CRC32_INIT;
    else if (en_i) crc_q <= crc_next_o;
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive frame checker: validates CRC-32 and length, strips the FCS through
// a 4-byte delay line, ends every frame with one eop/error status beat.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 1518,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  mac_clk,
  input  logic                  mac_rst_n,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_error,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_error,
  output logic [CNT_WIDTH-1:0]  frames_ok,
  output logic [CNT_WIDTH-1:0]  frames_bad,
  output state_t                dbg_state_o,
  output logic [31:0]           dbg_crc_o
);

  // Handshake: in_valid qualifies every input beat, there is no backpressure;
  // out_valid qualifies every output beat and the consumer must always accept.

  state_t                          state_q, state_d;
  logic [10:0]                     cnt_q, cnt_d, cnt_inc;
  logic                            err_q, err_d;
  logic [3:0][DATA_WIDTH-1:0]      dl_q, dl_d;
  logic [2:0]                      dl_cnt_q, dl_cnt_d;
  logic                            sent_q, sent_d;
  logic                            ov_d, osop_d, oeop_d, oerr_d;
  logic [DATA_WIDTH-1:0]           odata_d;
  logic                            crc_init, crc_en, bad;
  logic [31:0]                     crc_next;

  eth_crc32_d8 u_crc (
    .clk_i      (mac_clk),
    .rst_ni     (mac_rst_n),
    .init_i     (crc_init),
    .en_i       (crc_en),
    .data_i     (in_data),
    .crc_o      (dbg_crc_o),
    .crc_next_o (crc_next)
  );

  assign crc_init    = in_valid & in_startofpacket;
  assign crc_en      = in_valid & (in_startofpacket | (state_q == S_IN_FRAME));
  assign cnt_inc     = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
  assign bad         = (crc_next != CRC32_RESIDUE) ||
                       (32'(cnt_inc) < ETH_MIN_FRAME) ||
                       (32'(cnt_inc) > MAX_LEN) ||
                       err_q || in_error;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    dl_d     = dl_q;
    dl_cnt_d = dl_cnt_q;
    sent_d   = sent_q;
    ov_d     = 1'b0;
    osop_d   = 1'b0;
    oeop_d   = 1'b0;
    oerr_d   = 1'b0;
    odata_d  = out_data;
    if (in_valid && in_startofpacket) begin
      // A sop inside a frame closes the old frame as truncated.
      if (state_q == S_IN_FRAME) begin
        ov_d    = 1'b1;
        oeop_d  = 1'b1;
        oerr_d  = 1'b1;
        osop_d  = !sent_q;
        odata_d = (dl_cnt_q == 3'd4) ? dl_q[3] : '0;
      end else if (in_endofpacket) begin
        ov_d    = 1'b1;
        osop_d  = 1'b1;
        oeop_d  = 1'b1;
        oerr_d  = 1'b1;
        odata_d = '0;
      end
      cnt_d    = 11'd1;
      err_d    = in_error;
      dl_d[0]  = in_data;
      dl_cnt_d = 3'd1;
      sent_d   = 1'b0;
      state_d  = in_endofpacket ? S_IDLE : S_IN_FRAME;
      if (in_endofpacket) dl_cnt_d = 3'd0;
    end else if (in_valid && (state_q == S_IN_FRAME)) begin
      cnt_d    = cnt_inc;
      err_d    = err_q | in_error;
      dl_d     = {dl_q[2:0], in_data};
      dl_cnt_d = (dl_cnt_q == 3'd4) ? 3'd4 : dl_cnt_q + 3'd1;
      if (dl_cnt_q == 3'd4) begin
        ov_d    = 1'b1;
        osop_d  = !sent_q;
        odata_d = dl_q[3];
        sent_d  = 1'b1;
      end
      if (in_endofpacket) begin
        if (cnt_inc >= 11'd5) begin
          oeop_d = 1'b1;
          oerr_d = bad;
        end else begin
          ov_d    = 1'b1;
          osop_d  = 1'b1;
          oeop_d  = 1'b1;
          oerr_d  = 1'b1;
          odata_d = '0;
        end
        state_d  = S_IDLE;
        dl_cnt_d = 3'd0;
        sent_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge mac_clk) begin
    if (!mac_rst_n) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      err_q             <= 1'b0;
      dl_q              <= '0;
      dl_cnt_q          <= '0;
      sent_q            <= 1'b0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_error         <= 1'b0;
      out_data          <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      err_q             <= err_d;
      dl_q              <= dl_d;
      dl_cnt_q          <= dl_cnt_d;
      sent_q            <= sent_d;
      out_valid         <= ov_d;
      out_startofpacket <= osop_d;
      out_endofpacket   <= oeop_d;
      out_error         <= oerr_d;
      out_data          <= odata_d;
    end
  end

  // Statistics follow the registered status beat, one cycle behind it.
  always_ff @(posedge mac_clk) begin
    if (!mac_rst_n) begin
      frames_ok  <= '0;
      frames_bad <= '0;
    end else if (out_valid && out_endofpacket) begin
      if (out_error) frames_bad <= frames_bad + 1'b1;
      else           frames_ok  <= frames_ok + 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: frames are built in a buffer, expected
// output beats go into a queue, and a negedge monitor checks every beat.
module tb_eth_rx_fcs_check;
  import eth_pkg::*;

  logic        mac_clk, mac_rst_n;
  logic        in_sop, in_eop, in_valid, in_err;
  logic [7:0]  in_data;
  logic        out_sop, out_eop, out_valid, out_err;
  logic [7:0]  out_data;
  logic [31:0] frames_ok, frames_bad, dbg_crc;
  state_t      dbg_state;

  int          checks = 0;
  int          errors = 0;
  int          exp_ok = 0;
  int          exp_bad = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  fbuf[0:1599];
  int          flen;

  eth_rx_fcs_check dut (
    .mac_clk           (mac_clk),
    .mac_rst_n         (mac_rst_n),
    .in_startofpacket  (in_sop),
    .in_endofpacket    (in_eop),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_error          (in_err),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_error         (out_err),
    .frames_ok         (frames_ok),
    .frames_bad        (frames_bad),
    .dbg_state_o       (dbg_state),
    .dbg_crc_o         (dbg_crc)
  );

  // clock / reset
  initial mac_clk = 1'b0;
  always #5 mac_clk = ~mac_clk;

  // reference CRC: xor the byte in, then shift eight times
  function automatic logic [31:0] ref_crc(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // scoreboard monitor
  always @(negedge mac_clk) begin
    logic [10:0] obs, e;
    if (out_valid) begin
      obs = {out_sop, out_eop, out_eop & out_err, out_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_beat observed=%h expected=none", obs);
      end else begin
        e = exp_q.pop_front();
        assert (obs === e) else begin
          errors++;
          $error("FAIL out_beat observed=%h expected=%h", obs, e);
        end
      end
    end else begin
      checks++;
      assert ({out_sop, out_eop, out_err} === 3'b000) else begin
        errors++;
        $error("FAIL idle_flags observed=%b expected=000", {out_sop, out_eop, out_err});
      end
    end
  end

  // driver tasks
  task automatic drive_byte(input logic [7:0] d, input logic s, input logic e, input logic r);
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_err = r;
    @(negedge mac_clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0;
  endtask

  // unqualified sop/eop/error during a gap must be ignored
  task automatic idle_gap();
    in_valid = 1'b0; in_sop = 1'b1; in_eop = 1'b1; in_err = 1'b1;
    in_data = 8'($urandom_range(0, 255));
    @(negedge mac_clk);
    in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge mac_clk);
  endtask

  task automatic add_fcs(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = ref_crc(c, fbuf[i]);
    c = ~c;
    for (int j = 0; j < 4; j++) fbuf[n + j] = c[8*j +: 8];
    flen = n + 4;
  endtask

  task automatic send_frame(input int bad, input int err_idx, input int gap);
    if (flen >= 5) begin
      for (int k = 0; k <= flen - 5; k++)
        exp_q.push_back({(k == 0), (k == flen - 5), ((k == flen - 5) && (bad != 0)), fbuf[k]});
    end else begin
      exp_q.push_back({1'b1, 1'b1, 1'b1, 8'h00});
    end
    if (bad != 0) exp_bad++; else exp_ok++;
    for (int i = 0; i < flen; i++) begin
      drive_byte(fbuf[i], (i == 0), (i == flen - 1), (i == err_idx));
      if (gap != 0 && (i % gap) == gap - 1 && i != flen - 1) idle_gap();
    end
  endtask

  // drives n bytes with no eop; the close beat appears on the next sop
  task automatic send_trunc(input int n);
    for (int k = 0; k <= n - 5; k++)
      exp_q.push_back({(k == 0), 1'b0, 1'b0, fbuf[k]});
    exp_q.push_back({(n <= 4), 1'b1, 1'b1, (n >= 4) ? fbuf[n - 4] : 8'h00});
    exp_bad++;
    for (int i = 0; i < n; i++) drive_byte(fbuf[i], (i == 0), 1'b0, 1'b0);
  endtask

  task automatic check_counters(input string tag);
    idle(2);
    chk({tag, "_ok"}, frames_ok, 32'(exp_ok));
    chk({tag, "_bad"}, frames_bad, 32'(exp_bad));
  endtask

  initial begin
    mac_rst_n = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0; in_data = 8'h00;
    idle(3);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_state", {31'h0, dbg_state}, {31'h0, S_IDLE});
    chk("rst_crc", dbg_crc, 32'hFFFFFFFF);
    chk("rst_ok", frames_ok, 32'h0);
    chk("rst_bad", frames_bad, 32'h0);
    mac_rst_n = 1'b1;
    idle(2);

    // good 64-byte frame, back-to-back, with eop and counter latency checks
    for (int i = 0; i < 60; i++) fbuf[i] = 8'(i);
    add_fcs(60);
    send_frame(0, -1, 0);
    chk("eop_t_plus_1", {30'h0, out_valid, out_eop}, 32'h3);
    chk("ok_not_yet", frames_ok, 32'h0);
    idle(1);
    chk("ok_t_plus_2", frames_ok, 32'h1);
    check_counters("good64");

    // "123456789" with its known FCS: CRC passes, runt length fails
    for (int i = 0; i < 9; i++) fbuf[i] = 8'h31 + 8'(i);
    fbuf[9] = 8'h26; fbuf[10] = 8'h39; fbuf[11] = 8'hF4; fbuf[12] = 8'hCB;
    flen = 13;
    send_frame(1, -1, 0);
    check_counters("runt13");

    // corrupted byte 10
    for (int i = 0; i < 60; i++) fbuf[i] = 8'(i * 3 + 1);
    add_fcs(60);
    fbuf[10] = fbuf[10] ^ 8'h01;
    send_frame(1, -1, 5);
    check_counters("crc_bad");

    // PHY error on byte 20
    for (int i = 0; i < 60; i++) fbuf[i] = 8'(i * 3 + 1);
    add_fcs(60);
    send_frame(1, 20, 0);
    check_counters("phy_err");

    // 1519 bytes: one over the limit
    for (int i = 0; i < 1515; i++) fbuf[i] = 8'(i ^ (i >> 8));
    add_fcs(1515);
    send_frame(1, -1, 0);
    check_counters("len1519");

    // 1518 bytes: exactly the limit
    add_fcs(1514);
    send_frame(0, -1, 0);
    check_counters("len1518");

    // 63 bytes with a correct FCS: one short of the minimum
    for (int i = 0; i < 59; i++) fbuf[i] = 8'hA0 ^ 8'(i);
    add_fcs(59);
    send_frame(1, -1, 0);
    check_counters("len63");

    // sop+eop single byte
    fbuf[0] = 8'hAA;
    flen = 1;
    send_frame(1, -1, 0);
    check_counters("single");

    // good frame with periodic gaps
    for (int i = 0; i < 80; i++) fbuf[i] = 8'($urandom_range(0, 255));
    add_fcs(80);
    send_frame(0, -1, 3);
    check_counters("gaps");

    // frame A truncated after 30 bytes by frame B
    for (int i = 0; i < 30; i++) fbuf[i] = 8'hC0 + 8'(i);
    send_trunc(30);
    for (int i = 0; i < 60; i++) fbuf[i] = 8'(8'h55 + i);
    add_fcs(60);
    send_frame(0, -1, 0);
    check_counters("trunc30");

    // truncation before any byte is emitted
    fbuf[0] = 8'h11; fbuf[1] = 8'h22;
    send_trunc(2);
    for (int i = 0; i < 60; i++) fbuf[i] = 8'(8'h77 - i);
    add_fcs(60);
    send_frame(0, -1, 0);
    check_counters("trunc2");

    // reset during byte 40 of a good frame: no eop, counters cleared
    for (int i = 0; i < 60; i++) fbuf[i] = 8'(8'h10 + i);
    add_fcs(60);
    for (int k = 0; k < 36; k++) exp_q.push_back({(k == 0), 1'b0, 1'b0, fbuf[k]});
    for (int i = 0; i < 40; i++) drive_byte(fbuf[i], (i == 0), 1'b0, 1'b0);
    mac_rst_n = 1'b0;
    drive_byte(fbuf[40], 1'b0, 1'b0, 1'b0);
    mac_rst_n = 1'b1;
    chk("midrst_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_state", {31'h0, dbg_state}, {31'h0, S_IDLE});
    for (int i = 41; i < flen; i++) drive_byte(fbuf[i], 1'b0, (i == flen - 1), 1'b0);
    exp_ok = 0;
    exp_bad = 0;
    check_counters("midrst");
    send_frame(0, -1, 0);
    check_counters("after_rst");

    idle(4);
    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
